// File: rtl/mem_access_pkg.sv
// mem_access_pkg
// Shared definitions for the MEM-stage load/store responder:
//   - bus/data widths
//   - data type encodings (datatype_no, byte, half, word, ubyte, uhalf)
//   - FSM state codes
//   - lane helpers (byte enables, store-data replication, misalignment test)
package mem_access_pkg;

  localparam int MEM_DATA_W = 32;
  localparam int MEM_BE_W   = 4;
  localparam int MEM_REG_W  = 5;

  // Data type encodings
  localparam logic [2:0] DT_NO    = 3'b000;
  localparam logic [2:0] DT_BYTE  = 3'b001;
  localparam logic [2:0] DT_HALF  = 3'b010;
  localparam logic [2:0] DT_WORD  = 3'b011;
  localparam logic [2:0] DT_UBYTE = 3'b101;
  localparam logic [2:0] DT_UHALF = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  // Byte enables for an access of the given type at byte offset a.
  // Unknown types (including datatype_no) are handled as a full word.
  function automatic logic [3:0] lane_be(input logic [2:0] dtype, input logic [1:0] a);
    logic [3:0] be;
    case (dtype)
      DT_BYTE, DT_UBYTE: be = 4'b0001 << a;
      DT_HALF, DT_UHALF: be = a[1] ? 4'b1100 : 4'b0011;
      default:           be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate right-justified store data into every lane so the byte
  // enables alone select which bytes the memory takes.
  function automatic logic [31:0] lane_wdata(input logic [2:0] dtype, input logic [31:0] d);
    logic [31:0] w;
    case (dtype)
      DT_BYTE, DT_UBYTE: w = {4{d[7:0]}};
      DT_HALF, DT_UHALF: w = {2{d[15:0]}};
      default:           w = d;
    endcase
    return w;
  endfunction

  // True when the access does not sit on its natural boundary.
  function automatic logic is_misaligned(input logic [2:0] dtype, input logic [1:0] a);
    logic m;
    case (dtype)
      DT_BYTE, DT_UBYTE: m = 1'b0;
      DT_HALF, DT_UHALF: m = a[0];
      default:           m = (a != 2'b00);
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// mem_load_align
// Combinational load-data alignment: picks the addressed byte/half out of
// the bus word and sign- or zero-extends it to 32 bits.
// Ports:
//   rdata     in  32  raw bus read data
//   addr_lo   in  2   byte offset of the load
//   data_type in  3   load data type
//   data      out 32  aligned, extended load data
module mem_load_align
  import mem_access_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  data_type,
  output logic [31:0] data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Select the addressed byte lane and half-word lane
  always_comb begin
    byte_s = 8'h00;
    case (addr_lo)
      2'b00:   byte_s = rdata[7:0];
      2'b01:   byte_s = rdata[15:8];
      2'b10:   byte_s = rdata[23:16];
      2'b11:   byte_s = rdata[31:24];
      default: byte_s = rdata[7:0];
    endcase
    if (addr_lo[1]) begin
      half_s = rdata[31:16];
    end else begin
      half_s = rdata[15:0];
    end
  end

  // Extend the selected lane according to the data type
  always_comb begin
    data = rdata;
    case (data_type)
      DT_BYTE:  data = {{24{byte_s[7]}}, byte_s};
      DT_UBYTE: data = {24'h000000, byte_s};
      DT_HALF:  data = {{16{half_s[15]}}, half_s};
      DT_UHALF: data = {16'h0000, half_s};
      default:  data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// mem_access
// MEM-stage responder: accepts one load or store from EX, runs it as a
// single req/gnt/rvalid transaction on the data bus while stalling the
// pipeline, and returns aligned, extended load data to writeback.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   r_mem_enable_i / r_mem_addr_i   load request and byte address
//   w_mem_enable_i / w_mem_addr_i   store request and byte address (store wins)
//   w_mem_data_i                    right-justified store data
//   data_type_i                     access data type
//   mem_w_reg_enable_i, w_reg_addr_i  load writeback request and target
//   bus_req_o/we/addr/be/wdata      data bus request side
//   bus_gnt_i, bus_rvalid_i, bus_rdata_i  data bus response side
//   stall_o                         hold IF/ID/EX
//   mem_w_reg_enable_o/addr/data    one-cycle writeback of load result
// Build option MEM_MISALIGN_TRAP_EN: misaligned half/word accesses skip
// the bus entirely and pulse misalign_o with the byte address on
// misalign_addr_o. Without it the low address bits are dropped.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int DATA_W = MEM_DATA_W,
  parameter int BE_W   = MEM_BE_W
)(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 r_mem_enable_i,
  input  logic [DATA_W-1:0]    r_mem_addr_i,
  input  logic                 w_mem_enable_i,
  input  logic [DATA_W-1:0]    w_mem_addr_i,
  input  logic [DATA_W-1:0]    w_mem_data_i,
  input  logic [2:0]           data_type_i,
  input  logic                 mem_w_reg_enable_i,
  input  logic [MEM_REG_W-1:0] w_reg_addr_i,
  output logic                 bus_req_o,
  output logic                 bus_we_o,
  output logic [DATA_W-1:0]    bus_addr_o,
  output logic [BE_W-1:0]      bus_be_o,
  output logic [DATA_W-1:0]    bus_wdata_o,
  input  logic                 bus_gnt_i,
  input  logic                 bus_rvalid_i,
  input  logic [DATA_W-1:0]    bus_rdata_i,
  output logic                 stall_o,
  output logic                 mem_w_reg_enable_o,
  output logic [MEM_REG_W-1:0] mem_w_reg_addr_o,
  output logic [DATA_W-1:0]    mem_w_reg_data_o
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic                 misalign_o,
  output logic [DATA_W-1:0]    misalign_addr_o
`endif
);

  state_e                state_r;
  logic [DATA_W-1:0]     addr_r;
  logic [2:0]            dtype_r;
  logic                  we_r;
  logic                  reg_en_r;
  logic [MEM_REG_W-1:0]  reg_addr_r;
  logic                  bus_req_r;
  logic [BE_W-1:0]       bus_be_r;
  logic [DATA_W-1:0]     bus_wdata_r;
  logic                  wb_en_r;
  logic [MEM_REG_W-1:0]  wb_addr_r;
  logic [DATA_W-1:0]     wb_data_r;

  logic                  acc_s;
  logic [DATA_W-1:0]     addr_s;
  logic                  stall_s;
  logic [DATA_W-1:0]     load_data_s;

`ifdef MEM_MISALIGN_TRAP_EN
  logic                  misalign_r;
  logic [DATA_W-1:0]     misalign_addr_r;
  logic                  misalign_s;
  assign misalign_s = is_misaligned(data_type_i, addr_s[1:0]);
`endif

  // Request decode: a store takes priority over a simultaneous load
  always_comb begin
    acc_s = r_mem_enable_i | w_mem_enable_i;
    if (w_mem_enable_i) begin
      addr_s = w_mem_addr_i;
    end else begin
      addr_s = r_mem_addr_i;
    end
  end

  // Stall covers the accepting IDLE cycle and the whole bus transaction
  always_comb begin
    stall_s = 1'b0;
    case (state_r)
      ST_IDLE:         stall_s = acc_s;
      ST_REQ, ST_WAIT: stall_s = 1'b1;
      default:         stall_s = 1'b0;
    endcase
  end

  mem_load_align u_load_align (
    .rdata     (bus_rdata_i),
    .addr_lo   (addr_r[1:0]),
    .data_type (dtype_r),
    .data      (load_data_s)
  );

  // Transaction FSM with registered bus and writeback outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      addr_r      <= '0;
      dtype_r     <= 3'b000;
      we_r        <= 1'b0;
      reg_en_r    <= 1'b0;
      reg_addr_r  <= '0;
      bus_req_r   <= 1'b0;
      bus_be_r    <= '0;
      bus_wdata_r <= '0;
      wb_en_r     <= 1'b0;
      wb_addr_r   <= '0;
      wb_data_r   <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_r      <= 1'b0;
      misalign_addr_r <= '0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          wb_en_r <= 1'b0;
          if (acc_s) begin
            addr_r      <= addr_s;
            dtype_r     <= data_type_i;
            we_r        <= w_mem_enable_i;
            // A store (even with a load also requested) never writes back
            reg_en_r    <= mem_w_reg_enable_i & ~w_mem_enable_i;
            reg_addr_r  <= w_reg_addr_i;
            bus_be_r    <= lane_be(data_type_i, addr_s[1:0]);
            bus_wdata_r <= lane_wdata(data_type_i, w_mem_data_i);
`ifdef MEM_MISALIGN_TRAP_EN
            if (misalign_s) begin
              misalign_r      <= 1'b1;
              misalign_addr_r <= addr_s;
              state_r         <= ST_DONE;
            end else begin
              bus_req_r <= 1'b1;
              state_r   <= ST_REQ;
            end
`else
            bus_req_r <= 1'b1;
            state_r   <= ST_REQ;
`endif
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_REQ: begin
          if (bus_gnt_i) begin
            bus_req_r <= 1'b0;
            state_r   <= we_r ? ST_DONE : ST_WAIT;
          end else begin
            state_r <= ST_REQ;
          end
        end
        ST_WAIT: begin
          if (bus_rvalid_i) begin
            wb_data_r <= load_data_s;
            wb_addr_r <= reg_addr_r;
            wb_en_r   <= reg_en_r;
            state_r   <= ST_DONE;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_DONE: begin
          // EX advances at the end of this cycle, so nothing is accepted here
          wb_en_r <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
          misalign_r <= 1'b0;
`endif
          state_r <= ST_IDLE;
        end
        default: begin
          bus_req_r <= 1'b0;
          wb_en_r   <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus_req_o          = bus_req_r;
  assign bus_we_o           = we_r;
  assign bus_addr_o         = {addr_r[DATA_W-1:2], 2'b00};
  assign bus_be_o           = bus_be_r;
  assign bus_wdata_o        = bus_wdata_r;
  assign stall_o            = stall_s;
  assign mem_w_reg_enable_o = wb_en_r;
  assign mem_w_reg_addr_o   = wb_addr_r;
  assign mem_w_reg_data_o   = wb_data_r;
`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign_o         = misalign_r;
  assign misalign_addr_o    = misalign_addr_r;
`endif

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access
// Self-checking bench for mem_access: a table of load/store vectors with
// expected bus and writeback values, plus hand sequences for reset
// mid-transaction and the misaligned word load.
module tb_mem_access;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        r_en, w_en, reg_en, gnt, rvalid;
  logic [31:0] r_addr, w_addr, w_data, rdata;
  logic [2:0]  dtype;
  logic [4:0]  reg_addr;
  logic        bus_req, bus_we, stall, wb_en;
  logic [31:0] bus_addr, bus_wdata, wb_data;
  logic [3:0]  bus_be;
  logic [4:0]  wb_addr;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign;
  logic [31:0] misalign_addr;
`endif

  always #5 clk = ~clk;

  mem_access dut (
    .clk(clk), .rst_n(rst_n),
    .r_mem_enable_i(r_en), .r_mem_addr_i(r_addr),
    .w_mem_enable_i(w_en), .w_mem_addr_i(w_addr), .w_mem_data_i(w_data),
    .data_type_i(dtype), .mem_w_reg_enable_i(reg_en), .w_reg_addr_i(reg_addr),
    .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_addr_o(bus_addr),
    .bus_be_o(bus_be), .bus_wdata_o(bus_wdata),
    .bus_gnt_i(gnt), .bus_rvalid_i(rvalid), .bus_rdata_i(rdata),
    .stall_o(stall), .mem_w_reg_enable_o(wb_en),
    .mem_w_reg_addr_o(wb_addr), .mem_w_reg_data_o(wb_data)
`ifdef MEM_MISALIGN_TRAP_EN
    , .misalign_o(misalign), .misalign_addr_o(misalign_addr)
`endif
  );

  typedef struct {
    logic        we;
    logic        both;
    logic [2:0]  dt;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        reg_en;
    logic [4:0]  reg_addr;
    int          gnt_dly;
    logic [31:0] exp_baddr;
    logic [3:0]  exp_be;
    logic [31:0] exp_bwdata;
    logic        exp_wb_en;
    logic [31:0] exp_wb_data;
  } vec_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_exp_t;

  typedef struct {
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_exp_t;

  bus_exp_t bus_q[$];
  wb_exp_t  wb_q[$];
  int n_vec  = 0;
  int n_miss = 0;

  localparam int NV = 16;
  vec_t vt[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Runs one transaction starting just after a posedge with the DUT idle;
  // returns just after a posedge with the DUT idle again.
  task automatic run_vec(input vec_t v);
    bus_exp_t bx;
    wb_exp_t  wx;
    r_en     = !v.we || v.both;
    w_en     = v.we;
    r_addr   = v.both ? (v.addr + 32'h40) : (v.we ? 32'h0000_0ABC : v.addr);
    w_addr   = v.we ? v.addr : 32'h0000_0FF0;
    w_data   = v.we ? v.wdata : 32'h5A5A_5A5A;
    dtype    = v.dt;
    reg_en   = v.reg_en;
    reg_addr = v.reg_addr;
    bus_q.push_back('{v.we, v.exp_baddr, v.exp_be, v.exp_bwdata});
    wb_q.push_back('{v.exp_wb_en, v.reg_addr, v.exp_wb_data});
    @(negedge clk);
    check("stall_accept", {31'b0, stall}, 32'd1);
    @(posedge clk); #1;
    // scramble inputs so only latched values can satisfy the bus checks
    r_en = 1'b0; w_en = 1'b0; reg_en = 1'b0;
    r_addr = 32'hFFFF_FFFF; w_addr = 32'hEEEE_EEEE; w_data = 32'h0;
    dtype = 3'b111; reg_addr = 5'd31;
    bx = bus_q.pop_front();
    for (int i = 0; i <= v.gnt_dly; i++) begin
      gnt = (i == v.gnt_dly);
      @(negedge clk);
      check("bus_req",  {31'b0, bus_req}, 32'd1);
      check("bus_we",   {31'b0, bus_we}, {31'b0, bx.we});
      check("bus_addr", bus_addr, bx.addr);
      check("bus_be",   {28'b0, bus_be}, {28'b0, bx.be});
      if (bx.we) check("bus_wdata", bus_wdata, bx.wdata);
      check("stall_req", {31'b0, stall}, 32'd1);
      @(posedge clk); #1;
    end
    gnt = 1'b0;
    if (!v.we) begin
      rvalid = 1'b1;
      rdata  = v.rdata;
      @(negedge clk);
      check("req_drop_wait", {31'b0, bus_req}, 32'd0);
      check("stall_wait",    {31'b0, stall}, 32'd1);
      @(posedge clk); #1;
      rvalid = 1'b0;
      rdata  = 32'h0;
    end
    wx = wb_q.pop_front();
    @(negedge clk);
    check("stall_done", {31'b0, stall}, 32'd0);
    check("wb_en",      {31'b0, wb_en}, {31'b0, wx.en});
    if (wx.en) begin
      check("wb_addr", {27'b0, wb_addr}, {27'b0, wx.addr});
      check("wb_data", wb_data, wx.data);
    end
    @(posedge clk); #1;
    @(negedge clk);
    check("idle_req",   {31'b0, bus_req}, 32'd0);
    check("idle_stall", {31'b0, stall}, 32'd0);
    check("wb_pulse",   {31'b0, wb_en}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t mis;
    //        we   both dt        addr          wdata         rdata         ren  rd     dly  baddr         be       bwdata        wben exp_wb
    vt[0]  = '{1'b0,1'b0,DT_WORD, 32'h0000_0100,32'h0,        32'hDEAD_BEEF,1'b1,5'd5, 0,  32'h0000_0100,4'b1111,32'h0,        1'b1,32'hDEAD_BEEF};
    vt[1]  = '{1'b0,1'b0,DT_BYTE, 32'h0000_0103,32'h0,        32'h8011_2233,1'b1,5'd6, 0,  32'h0000_0100,4'b1000,32'h0,        1'b1,32'hFFFF_FF80};
    vt[2]  = '{1'b0,1'b0,DT_UBYTE,32'h0000_0103,32'h0,        32'h8011_2233,1'b1,5'd7, 0,  32'h0000_0100,4'b1000,32'h0,        1'b1,32'h0000_0080};
    vt[3]  = '{1'b0,1'b0,DT_UHALF,32'h0000_0102,32'h0,        32'h8011_2233,1'b1,5'd8, 0,  32'h0000_0100,4'b1100,32'h0,        1'b1,32'h0000_8011};
    vt[4]  = '{1'b0,1'b0,DT_HALF, 32'h0000_0100,32'h0,        32'h1234_F00D,1'b1,5'd9, 2,  32'h0000_0100,4'b0011,32'h0,        1'b1,32'hFFFF_F00D};
    vt[5]  = '{1'b0,1'b0,DT_BYTE, 32'h0000_0101,32'h0,        32'h8011_2233,1'b1,5'd10,0,  32'h0000_0100,4'b0010,32'h0,        1'b1,32'h0000_0022};
    vt[6]  = '{1'b0,1'b0,DT_HALF, 32'h0000_0102,32'h0,        32'h8011_2233,1'b1,5'd11,0,  32'h0000_0100,4'b1100,32'h0,        1'b1,32'hFFFF_8011};
    vt[7]  = '{1'b1,1'b0,DT_HALF, 32'h0000_0106,32'h1234_ABCD,32'h0,        1'b0,5'd0, 3,  32'h0000_0104,4'b1100,32'hABCD_ABCD,1'b0,32'h0};
    vt[8]  = '{1'b1,1'b0,DT_BYTE, 32'h0000_0201,32'h0000_00A5,32'h0,        1'b0,5'd0, 0,  32'h0000_0200,4'b0010,32'hA5A5_A5A5,1'b0,32'h0};
    vt[9]  = '{1'b1,1'b0,DT_WORD, 32'h0000_0300,32'hCAFE_F00D,32'h0,        1'b0,5'd0, 1,  32'h0000_0300,4'b1111,32'hCAFE_F00D,1'b0,32'h0};
    vt[10] = '{1'b1,1'b1,DT_WORD, 32'h0000_0040,32'h1122_3344,32'h0,        1'b1,5'd12,0,  32'h0000_0040,4'b1111,32'h1122_3344,1'b0,32'h0};
    vt[11] = '{1'b0,1'b0,DT_NO,   32'h0000_010C,32'h0,        32'h8765_4321,1'b1,5'd13,0,  32'h0000_010C,4'b1111,32'h0,        1'b1,32'h8765_4321};
    vt[12] = '{1'b0,1'b0,DT_WORD, 32'h0000_0110,32'h0,        32'hA5A5_0001,1'b1,5'd0, 0,  32'h0000_0110,4'b1111,32'h0,        1'b1,32'hA5A5_0001};
    vt[13] = '{1'b0,1'b0,DT_WORD, 32'h0000_0114,32'h0,        32'hFFFF_0000,1'b0,5'd14,0,  32'h0000_0114,4'b1111,32'h0,        1'b0,32'h0};
    vt[14] = '{1'b0,1'b0,DT_UBYTE,32'h0000_0102,32'h0,        32'h8011_2233,1'b1,5'd14,1,  32'h0000_0100,4'b0100,32'h0,        1'b1,32'h0000_0011};
    vt[15] = '{1'b1,1'b0,DT_UHALF,32'h0000_0100,32'h0000_BEEF,32'h0,        1'b0,5'd0, 0,  32'h0000_0100,4'b0011,32'hBEEF_BEEF,1'b0,32'h0};
    mis    = '{1'b0,1'b0,DT_WORD, 32'h0000_0102,32'h0,        32'h0BAD_F00D,1'b1,5'd15,0,  32'h0000_0100,4'b1111,32'h0,        1'b1,32'h0BAD_F00D};

    rst_n = 1'b0; r_en = 1'b0; w_en = 1'b0; reg_en = 1'b0; gnt = 1'b0; rvalid = 1'b0;
    r_addr = 32'h0; w_addr = 32'h0; w_data = 32'h0; rdata = 32'h0; dtype = 3'b000; reg_addr = 5'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req",    {31'b0, bus_req}, 32'd0);
    check("rst_we",     {31'b0, bus_we}, 32'd0);
    check("rst_addr",   bus_addr, 32'h0);
    check("rst_be",     {28'b0, bus_be}, 32'd0);
    check("rst_wdata",  bus_wdata, 32'h0);
    check("rst_stall",  {31'b0, stall}, 32'd0);
    check("rst_wb_en",  {31'b0, wb_en}, 32'd0);
    check("rst_wb_dat", wb_data, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < NV; k++) run_vec(vt[k]);

    // Reset while waiting for read data abandons the load
    r_en = 1'b1; r_addr = 32'h0000_0100; dtype = DT_WORD; reg_en = 1'b1; reg_addr = 5'd7;
    @(posedge clk); #1;
    r_en = 1'b0; reg_en = 1'b0; gnt = 1'b1;
    @(posedge clk); #1;
    gnt = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    check("wait_stall", {31'b0, stall}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1; rvalid = 1'b1; rdata = 32'h1234_5678;
    @(negedge clk);
    check("rstw_stall", {31'b0, stall}, 32'd0);
    check("rstw_req",   {31'b0, bus_req}, 32'd0);
    check("rstw_wb_en", {31'b0, wb_en}, 32'd0);
    @(posedge clk); #1;
    rvalid = 1'b0; rdata = 32'h0;
    @(negedge clk);
    check("late_rv_wb_en", {31'b0, wb_en}, 32'd0);
    check("late_rv_data",  wb_data, 32'h0);
    check("late_rv_stall", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;

`ifdef MEM_MISALIGN_TRAP_EN
    // Misaligned word load traps without touching the bus
    r_en = 1'b1; r_addr = mis.addr; dtype = DT_WORD; reg_en = 1'b1; reg_addr = mis.reg_addr;
    @(negedge clk);
    check("mis_stall", {31'b0, stall}, 32'd1);
    @(posedge clk); #1;
    r_en = 1'b0; reg_en = 1'b0;
    @(negedge clk);
    check("mis_pulse", {31'b0, misalign}, 32'd1);
    check("mis_addr",  misalign_addr, 32'h0000_0102);
    check("mis_req",   {31'b0, bus_req}, 32'd0);
    check("mis_wb",    {31'b0, wb_en}, 32'd0);
    check("mis_done",  {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("mis_clear", {31'b0, misalign}, 32'd0);
    check("mis_req2",  {31'b0, bus_req}, 32'd0);
    @(posedge clk); #1;
`else
    run_vec(mis);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Global watchdog so the bench always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
